// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared types and helpers for the digit-serial adder/subtractor.
//   - state_t   : FSM states (IDLE, RUN, DONE)
//   - MODE_SUB / MODE_ADD : encodings of the mode input
//   - cnt_width : width of the digit counter, clog2(WIDTH/DIGIT), min 1
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   function automatic int cnt_width(input int width, input int digit);
      int n;
      if (digit < 1) return 1;
      n = width / digit;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Operand/result bundle of serial_addsub.
//   Handshake semantics (both sides): a transfer happens on a rising clk
//   edge where valid && ready are both high. The producer holds its data
//   stable while valid is high and ready is low; the block's in_ready and
//   out_valid depend only on its state, never combinationally on the
//   partner's valid/ready.
//   Signals:
//     in_valid/in_ready   operand handshake
//     a, b, bin, mode     operands, borrow/carry-in, 0=sub 1=add
//     out_valid/out_ready result handshake
//     diff, borr          result and final borrow/carry-out
//     busy                high while digits are being processed
//     state               FSM state, for observation
//     ovf                 signed overflow (only with SERIAL_ADDSUB_OVF_EN)
//   master = operand producer / result consumer, slave = serial_addsub.
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          a;
   logic [WIDTH-1:0]          b;
   logic                      bin;
   logic                      mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          diff;
   logic                      borr;
   logic                      busy;
   serial_addsub_pkg::state_t state;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic                      ovf;

   modport master (
      output in_valid, a, b, bin, mode, out_ready,
      input  in_ready, out_valid, diff, borr, busy, state, ovf
   );
   modport slave (
      input  in_valid, a, b, bin, mode, out_ready,
      output in_ready, out_valid, diff, borr, busy, state, ovf
   );
`else
   modport master (
      output in_valid, a, b, bin, mode, out_ready,
      input  in_ready, out_valid, diff, borr, busy, state
   );
   modport slave (
      input  in_valid, a, b, bin, mode, out_ready,
      output in_ready, out_valid, diff, borr, busy, state
   );
`endif
endinterface

// File: rtl/serial_addsub_digit_addsub.sv
// digit_addsub
//   Combinational DIGIT-bit add/subtract cell.
//   Ports:
//     a_dig, b_dig : operand digits
//     flag_in      : borrow-in (sub) / carry-in (add)
//     mode         : MODE_SUB or MODE_ADD
//     d            : result digit
//     flag_out     : borrow-out (sub) / carry-out (add)
//     msb_cin      : borrow/carry into the digit's top bit (for overflow)
module digit_addsub
   import serial_addsub_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_dig,
   input  logic [DIGIT-1:0] b_dig,
   input  logic             flag_in,
   input  logic             mode,
   output logic [DIGIT-1:0] d,
   output logic             flag_out,
   output logic             msb_cin
);

   // One extra bit: for sub the top bit is set exactly when the result went
   // negative, i.e. the borrow-out; for add it is the carry-out.
   logic [DIGIT:0] full;

   always_comb begin
      if (mode == MODE_ADD)
         full = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, flag_in};
      else
         full = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, flag_in};
   end

   assign d        = full[DIGIT-1:0];
   assign flag_out = full[DIGIT];
   // Sum and difference bits are both a ^ b ^ (carry|borrow)-in, so the
   // incoming carry/borrow of the top bit can be recovered from its result.
   assign msb_cin  = d[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Digit-serial adder/subtractor: a-b-bin (mode=0) or a+b+cin (mode=1)
//   over WIDTH bits, DIGIT bits per clock, borrow/carry held in a flop.
//   Accept edge k -> out_valid after edge k+WIDTH/DIGIT; result held in
//   DONE until out_ready.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : serial_addsub_if.slave (operands, result, busy, state)
//   Optional: define SERIAL_ADDSUB_OVF_EN to add the signed overflow
//   output bus.ovf (valid with out_valid).
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic            clk,
   input logic            rst_n,
   serial_addsub_if.slave bus
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
      $error("serial_addsub: DIGIT must be in 1..WIDTH");
   end
   if (WIDTH % DIGIT != 0) begin : g_bad_width
      $error("serial_addsub: WIDTH must be a multiple of DIGIT");
   end

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  a_sh, b_sh, res, res_nxt;
   logic              mode_r, flag;
   logic [CW-1:0]     cnt;
   logic [DIGIT-1:0]  d_dig;
   logic              flag_out, msb_cin;
   logic              accept, last_dig, release_done;
   logic              in_ready_o, out_valid_o, busy_o;

   assign accept       = (state == IDLE) && bus.in_valid;
   assign last_dig     = (state == RUN) && (cnt == LAST);
   assign release_done = (state == DONE) && bus.out_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)       state_nxt = RUN;
         RUN:     if (last_dig)     state_nxt = DONE;
         DONE:    if (release_done) state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      unique case (state)
         IDLE:    in_ready_o  = 1'b1;
         RUN:     busy_o      = 1'b1;
         DONE:    out_valid_o = 1'b1;
         default: ;
      endcase
   end

   // ---------------- digit cell ----------------
   digit_addsub #(.DIGIT(DIGIT)) u_digit (
      .a_dig    (a_sh[DIGIT-1:0]),
      .b_dig    (b_sh[DIGIT-1:0]),
      .flag_in  (flag),
      .mode     (mode_r),
      .d        (d_dig),
      .flag_out (flag_out),
      .msb_cin  (msb_cin)
   );

   // New digit enters at the MSB end; after N digits the LSB digit has
   // travelled all the way down to bit 0.
   if (DIGIT == WIDTH) begin : g_res_full
      assign res_nxt = d_dig;
   end else begin : g_res_shift
      assign res_nxt = {d_dig, res[WIDTH-1:DIGIT]};
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res    <= '0;
         mode_r <= MODE_SUB;
         flag   <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh   <= bus.a;
         b_sh   <= bus.b;
         res    <= '0;
         mode_r <= bus.mode;
         flag   <= bus.bin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         res    <= res_nxt;
         flag   <= flag_out;
         cnt    <= cnt + CW'(1);
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   // Signed overflow: carry/borrow into the MSB differs from the one out.
   logic ovf_r;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            ovf_r <= 1'b0;
      else if (last_dig)     ovf_r <= msb_cin ^ flag_out;
      else if (release_done) ovf_r <= 1'b0;
   end
   assign bus.ovf = ovf_r;
`else
   logic unused_msb_cin;
   assign unused_msb_cin = msb_cin;
`endif

   assign bus.in_ready  = in_ready_o;
   assign bus.out_valid = out_valid_o;
   assign bus.busy      = busy_o;
   assign bus.diff      = res;
   assign bus.borr      = flag;
   assign bus.state     = state;

endmodule
